// File: rtl/adxl362_pkg.sv
// Shared definitions for the ADXL362 FIFO loader: entry tags, FIFO_MODE
// encodings, loader FSM states and the 16-bit entry packing helpers.
package adxl362_pkg;

    localparam int ENTRY_WIDTH   = 16;
    localparam int ENTRY_VALUE_W = 14;

    // Entry tag field [15:14]
    localparam logic [1:0] TAG_X = 2'b00;
    localparam logic [1:0] TAG_Y = 2'b01;
    localparam logic [1:0] TAG_Z = 2'b10;
    localparam logic [1:0] TAG_T = 2'b11;

    // FIFO_MODE encodings
    localparam logic [1:0] MODE_DIS    = 2'b00;
    localparam logic [1:0] MODE_OLDEST = 2'b01;
    localparam logic [1:0] MODE_STREAM = 2'b10;
    localparam logic [1:0] MODE_TRIG   = 2'b11;

    // Loader FSM: each WR_* state is the cycle in which that entry's write
    // strobe is presented to the FIFO.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR_X = 3'd1,
        WR_Y = 3'd2,
        WR_Z = 3'd3,
        WR_T = 3'd4
    } loader_state_e;

    // Tag that belongs to the entry written in a given state.
    function automatic logic [1:0] state_tag(input loader_state_e st);
        logic [1:0] tag;
        case (st)
            WR_X:    tag = TAG_X;
            WR_Y:    tag = TAG_Y;
            WR_Z:    tag = TAG_Z;
            WR_T:    tag = TAG_T;
            default: tag = TAG_X;
        endcase
        return tag;
    endfunction

    // Assemble one FIFO entry from a tag and an already sign-extended value.
    function automatic logic [ENTRY_WIDTH-1:0] pack_entry(
        input logic [1:0]               tag,
        input logic [ENTRY_VALUE_W-1:0] value
    );
        return {tag, value};
    endfunction

endpackage

// File: rtl/adxl362_fifo_loader.sv
// ADXL362 FIFO loader: serialises each X/Y/Z(/T) sample set into tagged
// 16-bit FIFO entries, applies the FIFO_MODE full policy, merges SPI pops
// with stream-mode discards, and tracks entry count, watermark and overrun.
module adxl362_fifo_loader
    import adxl362_pkg::*;
#(
    parameter int DEPTH        = 512,
    parameter int CNT_WIDTH    = $clog2(DEPTH) + 1,
    parameter int SAMPLE_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] x_data,
    input  logic [SAMPLE_WIDTH-1:0] y_data,
    input  logic [SAMPLE_WIDTH-1:0] z_data,
    input  logic [SAMPLE_WIDTH-1:0] temp_data,
    input  logic [1:0]              fifo_mode,
    input  logic                    fifo_temp,
    input  logic [CNT_WIDTH-1:0]    fifo_samples,
    input  logic                    spi_pop,
    input  logic                    fifo_full,
    input  logic                    fifo_empty,
    output logic                    fifo_write,
    output logic [ENTRY_WIDTH-1:0]  fifo_data,
    output logic                    fifo_read,
    output logic [CNT_WIDTH-1:0]    entries,
    output logic                    watermark,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    loader_state_e state_r;
    loader_state_e state_next_s;
    loader_state_e target_s;

    logic [1:0]              mode_r;
    logic                    temp_en_r;
    logic [SAMPLE_WIDTH-1:0] y_r;
    logic [SAMPLE_WIDTH-1:0] z_r;
    logic [SAMPLE_WIDTH-1:0] t_r;

    logic [1:0]              mode_s;
    logic                    stream_s;
    logic                    full_s;
    logic                    drop_s;
    logic                    suppress_s;
    logic                    write_s;
    logic                    discard_s;
    logic                    read_s;
    logic                    overrun_set_s;
    logic [SAMPLE_WIDTH-1:0] sample_s;
    logic [ENTRY_WIDTH-1:0]  data_s;
    logic [CNT_WIDTH-1:0]    entries_next_s;

    logic                    fifo_write_r;
    logic [ENTRY_WIDTH-1:0]  fifo_data_r;
    logic                    fifo_read_r;
    logic [CNT_WIDTH-1:0]    entries_r;
    logic                    watermark_r;
    logic                    overrun_r;

    // The first entry of a set is decided in IDLE, before the mode is
    // latched, so it uses the live mode; later entries use the latched one.
    assign mode_s   = (state_r == IDLE) ? fifo_mode : mode_r;
    assign stream_s = (mode_s == MODE_STREAM) || (mode_s == MODE_TRIG);

    // Our own count already includes a write still in flight to the FIFO,
    // so it catches "full" one cycle before the FIFO's flag does.
    assign full_s = fifo_full || (entries_r == CNT_MAX);

    assign drop_s = sample_valid && (state_r != IDLE) &&
                    (fifo_mode != MODE_DIS) && !flush;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic, including the oldest-saved abort when full.
    always_comb begin
        target_s     = IDLE;
        suppress_s   = 1'b0;
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (sample_valid && (fifo_mode != MODE_DIS)) begin
                    target_s = WR_X;
                end else begin
                    target_s = IDLE;
                end
            end
            WR_X: target_s = WR_Y;
            WR_Y: target_s = WR_Z;
            WR_Z: begin
                if (temp_en_r) begin
                    target_s = WR_T;
                end else begin
                    target_s = IDLE;
                end
            end
            WR_T:    target_s = IDLE;
            default: target_s = IDLE;
        endcase

        if (flush) begin
            state_next_s = IDLE;
        end else if ((target_s != IDLE) && full_s && (mode_s == MODE_OLDEST)) begin
            suppress_s   = 1'b1;
            state_next_s = IDLE;
        end else begin
            state_next_s = target_s;
        end
    end

    // Output decode for the entry that the next state will present.
    always_comb begin
        write_s       = 1'b0;
        discard_s     = 1'b0;
        read_s        = 1'b0;
        overrun_set_s = 1'b0;
        data_s        = {ENTRY_WIDTH{1'b0}};
        sample_s      = {SAMPLE_WIDTH{1'b0}};

        case (state_next_s)
            WR_X:    sample_s = x_data;
            WR_Y:    sample_s = y_r;
            WR_Z:    sample_s = z_r;
            WR_T:    sample_s = t_r;
            default: sample_s = {SAMPLE_WIDTH{1'b0}};
        endcase

        if (flush) begin
            write_s       = 1'b0;
            discard_s     = 1'b0;
            read_s        = 1'b0;
            overrun_set_s = 1'b0;
        end else begin
            write_s       = (state_next_s != IDLE);
            discard_s     = write_s && full_s && stream_s;
            read_s        = (spi_pop && !fifo_empty) || discard_s;
            overrun_set_s = drop_s || suppress_s || discard_s;
            if (write_s) begin
                data_s = pack_entry(state_tag(state_next_s),
                                    ENTRY_VALUE_W'($signed(sample_s)));
            end else begin
                data_s = {ENTRY_WIDTH{1'b0}};
            end
        end
    end

    // Entry count update, saturating at 0 and DEPTH.
    always_comb begin
        entries_next_s = entries_r;
        if (flush) begin
            entries_next_s = CNT_ZERO;
        end else if (write_s && !read_s) begin
            if (entries_r != CNT_MAX) begin
                entries_next_s = entries_r + CNT_ONE;
            end else begin
                entries_next_s = entries_r;
            end
        end else if (read_s && !write_s) begin
            if (entries_r != CNT_ZERO) begin
                entries_next_s = entries_r - CNT_ONE;
            end else begin
                entries_next_s = entries_r;
            end
        end else begin
            entries_next_s = entries_r;
        end
    end

    // Capture mode, temperature enable and the remaining samples on set accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r    <= MODE_DIS;
            temp_en_r <= 1'b0;
            y_r       <= {SAMPLE_WIDTH{1'b0}};
            z_r       <= {SAMPLE_WIDTH{1'b0}};
            t_r       <= {SAMPLE_WIDTH{1'b0}};
        end else if ((state_r == IDLE) && (state_next_s == WR_X)) begin
            mode_r    <= fifo_mode;
            temp_en_r <= fifo_temp;
            y_r       <= y_data;
            z_r       <= z_data;
            t_r       <= temp_data;
        end
    end

    // Registered FIFO strobes, entry count and watermark.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_write_r <= 1'b0;
            fifo_data_r  <= {ENTRY_WIDTH{1'b0}};
            fifo_read_r  <= 1'b0;
            entries_r    <= CNT_ZERO;
            watermark_r  <= 1'b0;
        end else begin
            fifo_write_r <= write_s;
            fifo_data_r  <= data_s;
            fifo_read_r  <= read_s;
            entries_r    <= entries_next_s;
            watermark_r  <= (entries_next_s > fifo_samples);
        end
    end

    // Sticky overrun; a new set condition beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (overrun_set_s) begin
            overrun_r <= 1'b1;
        end else if (overrun_clr) begin
            overrun_r <= 1'b0;
        end
    end

    assign fifo_write = fifo_write_r;
    assign fifo_data  = fifo_data_r;
    assign fifo_read  = fifo_read_r;
    assign entries    = entries_r;
    assign watermark  = watermark_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_adxl362_fifo_loader.sv
// Directed bench for adxl362_fifo_loader with a simple FIFO occupancy model
// supplying fifo_full / fifo_empty.
module tb_adxl362_fifo_loader;

    localparam int DEPTH        = 512;
    localparam int CNT_WIDTH    = 10;
    localparam int SAMPLE_WIDTH = 12;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    sample_valid;
    logic [SAMPLE_WIDTH-1:0] x_data;
    logic [SAMPLE_WIDTH-1:0] y_data;
    logic [SAMPLE_WIDTH-1:0] z_data;
    logic [SAMPLE_WIDTH-1:0] temp_data;
    logic [1:0]              fifo_mode;
    logic                    fifo_temp;
    logic [CNT_WIDTH-1:0]    fifo_samples;
    logic                    spi_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_write;
    logic [15:0]             fifo_data;
    logic                    fifo_read;
    logic [CNT_WIDTH-1:0]    entries;
    logic                    watermark;
    logic                    overrun;
    logic                    overrun_clr;

    int tests_run    = 0;
    int tests_failed = 0;
    int fifo_cnt     = 0;

    adxl362_fifo_loader #(
        .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH), .SAMPLE_WIDTH(SAMPLE_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .sample_valid(sample_valid),
        .x_data(x_data), .y_data(y_data), .z_data(z_data), .temp_data(temp_data),
        .fifo_mode(fifo_mode), .fifo_temp(fifo_temp), .fifo_samples(fifo_samples),
        .spi_pop(spi_pop), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_write(fifo_write), .fifo_data(fifo_data), .fifo_read(fifo_read),
        .entries(entries), .watermark(watermark), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    // Occupancy of the downstream FIFO as seen through the write/read strobes.
    always @(posedge clk) begin
        if (rst || flush) begin
            fifo_cnt <= 0;
        end else if (fifo_write && !fifo_read && fifo_cnt < DEPTH) begin
            fifo_cnt <= fifo_cnt + 1;
        end else if (!fifo_write && fifo_read && fifo_cnt > 0) begin
            fifo_cnt <= fifo_cnt - 1;
        end
    end

    assign fifo_full  = (fifo_cnt == DEPTH);
    assign fifo_empty = (fifo_cnt == 0);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one sample set and wait until the loader is back in IDLE.
    task automatic run_set(input logic [11:0] x, input logic [11:0] y,
                           input logic [11:0] z, input logic [11:0] t, input logic tmp);
        x_data = x; y_data = y; z_data = z; temp_data = t; fifo_temp = tmp;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (tmp ? 4 : 3) tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; sample_valid = 1'b0;
        x_data = 12'h000; y_data = 12'h000; z_data = 12'h000; temp_data = 12'h000;
        fifo_mode = 2'b00; fifo_temp = 1'b0; fifo_samples = 10'd10;
        spi_pop = 1'b0; overrun_clr = 1'b0;
        tick(); tick();
        check_val("rst_write", 32'(fifo_write), 32'd0);
        check_val("rst_data", 32'(fifo_data), 32'h0000);
        check_val("rst_read", 32'(fifo_read), 32'd0);
        check_val("rst_entries", 32'(entries), 32'd0);
        check_val("rst_wm", 32'(watermark), 32'd0);
        check_val("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick();

        // Stream mode, three-entry set
        fifo_mode = 2'b10; fifo_temp = 1'b0;
        x_data = 12'h7FF; y_data = 12'h800; z_data = 12'h001; temp_data = 12'hFFF;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check_val("t1_x_wr", 32'(fifo_write), 32'd1);
        check_val("t1_x_data", 32'(fifo_data), 32'h07FF);
        check_val("t1_x_cnt", 32'(entries), 32'd1);
        tick();
        check_val("t1_y_data", 32'(fifo_data), 32'h7800);
        tick();
        check_val("t1_z_data", 32'(fifo_data), 32'h8001);
        check_val("t1_z_cnt", 32'(entries), 32'd3);
        tick();
        check_val("t1_idle_wr", 32'(fifo_write), 32'd0);
        check_val("t1_idle_cnt", 32'(entries), 32'd3);
        check_val("t1_ovr", 32'(overrun), 32'd0);
        check_val("t1_read", 32'(fifo_read), 32'd0);

        // Temperature entry plus a sample arriving mid-set
        fifo_temp = 1'b1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check_val("t2_x_data", 32'(fifo_data), 32'h07FF);
        tick();
        check_val("t2_y_data", 32'(fifo_data), 32'h7800);
        check_val("t2_ovr_pre", 32'(overrun), 32'd0);
        x_data = 12'h123; fifo_temp = 1'b0;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check_val("t2_z_data", 32'(fifo_data), 32'h8001);
        check_val("t2_ovr_drop", 32'(overrun), 32'd1);
        tick();
        check_val("t2_t_wr", 32'(fifo_write), 32'd1);
        check_val("t2_t_data", 32'(fifo_data), 32'hFFFF);
        tick();
        check_val("t2_idle_wr", 32'(fifo_write), 32'd0);
        check_val("t2_cnt", 32'(entries), 32'd7);
        tick();
        check_val("t2_no_late_wr", 32'(fifo_write), 32'd0);
        check_val("t2_cnt_hold", 32'(entries), 32'd7);

        // Flush keeps overrun, clear drops it
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("fl_cnt", 32'(entries), 32'd0);
        check_val("fl_ovr_kept", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check_val("clr_ovr", 32'(overrun), 32'd0);

        // Watermark at fifo_samples=5
        fifo_samples = 10'd5; fifo_mode = 2'b10;
        run_set(12'h001, 12'h002, 12'h003, 12'h000, 1'b0);
        check_val("wm_cnt3", 32'(entries), 32'd3);
        fifo_temp = 1'b0;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        check_val("wm_at5_cnt", 32'(entries), 32'd5);
        check_val("wm_at5", 32'(watermark), 32'd0);
        tick();
        check_val("wm_at6_cnt", 32'(entries), 32'd6);
        check_val("wm_at6", 32'(watermark), 32'd1);
        tick();
        spi_pop = 1'b1;
        tick();
        spi_pop = 1'b0;
        check_val("pop_read", 32'(fifo_read), 32'd1);
        check_val("pop_cnt", 32'(entries), 32'd5);
        check_val("pop_wm", 32'(watermark), 32'd0);
        tick();
        check_val("pop_read_end", 32'(fifo_read), 32'd0);

        // Pop while empty
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        spi_pop = 1'b1;
        tick();
        spi_pop = 1'b0;
        check_val("empty_pop_read", 32'(fifo_read), 32'd0);
        check_val("empty_pop_cnt", 32'(entries), 32'd0);

        // Disabled mode ignores samples
        fifo_mode = 2'b00;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check_val("dis_wr", 32'(fifo_write), 32'd0);
        tick();
        check_val("dis_cnt", 32'(entries), 32'd0);
        check_val("dis_ovr", 32'(overrun), 32'd0);

        // Prefill to 511 entries in stream mode
        fifo_mode = 2'b10;
        repeat (127) run_set(12'h010, 12'h020, 12'h030, 12'h040, 1'b1);
        run_set(12'h011, 12'h021, 12'h031, 12'h041, 1'b0);
        check_val("fill_cnt", 32'(entries), 32'd511);
        check_val("fill_ovr", 32'(overrun), 32'd0);

        // Oldest-saved reaching full mid-set
        fifo_mode = 2'b01; fifo_temp = 1'b0;
        x_data = 12'h005; y_data = 12'h006; z_data = 12'h007;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check_val("old_x_wr", 32'(fifo_write), 32'd1);
        check_val("old_x_data", 32'(fifo_data), 32'h0005);
        check_val("old_cnt", 32'(entries), 32'd512);
        tick();
        check_val("old_y_wr", 32'(fifo_write), 32'd0);
        check_val("old_read", 32'(fifo_read), 32'd0);
        check_val("old_ovr", 32'(overrun), 32'd1);
        tick();
        check_val("old_z_wr", 32'(fifo_write), 32'd0);
        check_val("old_cnt_end", 32'(entries), 32'd512);

        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check_val("clr2_ovr", 32'(overrun), 32'd0);

        // Stream mode while full: write with discard
        fifo_mode = 2'b10;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("strm_wr%0d", i), 32'(fifo_write), 32'd1);
            check_val($sformatf("strm_rd%0d", i), 32'(fifo_read), 32'd1);
            check_val($sformatf("strm_cnt%0d", i), 32'(entries), 32'd512);
            tick();
        end
        check_val("strm_end_wr", 32'(fifo_write), 32'd0);
        check_val("strm_end_rd", 32'(fifo_read), 32'd0);
        check_val("strm_ovr", 32'(overrun), 32'd1);

        // Flush during WR_Y
        flush = 1'b1;
        tick();
        flush = 1'b0;
        x_data = 12'h7FF; y_data = 12'h800; z_data = 12'h001;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        check_val("mid_y_data", 32'(fifo_data), 32'h7800);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("mid_wr", 32'(fifo_write), 32'd0);
        check_val("mid_cnt", 32'(entries), 32'd0);
        check_val("mid_ovr", 32'(overrun), 32'd1);
        tick();
        check_val("mid_wr_after", 32'(fifo_write), 32'd0);

        // Reset clears overrun
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rst2_ovr", 32'(overrun), 32'd0);
        check_val("rst2_cnt", 32'(entries), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
